// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver.
//
// Deserializes a frame (start 0, 8 data bits LSB first, stop 1) arriving on
// RX_in into a byte. Sampling is centred on each bit: the start bit is
// re-checked `half` cycles after the detected falling edge, and every later
// sample is a whole bit period after the previous one.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   RX_in        serial line, asynchronous to clk, idles high
//   data_out     last correctly received byte (held until the next good frame)
//   data_valid   one-cycle pulse when data_out is updated
//   frame_error  one-cycle pulse when the stop bit samples low
//   RX_busy      high while a frame is in progress
//
// Parameter
//   clock_per_bit  clk cycles per UART bit, must be >= 4

module uart_rx #(
  parameter int clock_per_bit = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       RX_busy
);

  localparam int CNT_W = $clog2(clock_per_bit);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'((clock_per_bit - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(clock_per_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_out_q;
  logic             data_valid_q;
  logic             frame_error_q;
  logic             busy_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Receive FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= 3'd0;
          busy_q    <= 1'b0;
          if (!rx_s) begin
            state_q <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          // busy rises on the first START cycle, one cycle after entry.
          busy_q <= 1'b1;
          if (cnt_q == HALF_C) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= S_DATA;
            end else begin
              // Line went back high before mid-bit: a glitch, not a frame.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          busy_q <= 1'b1;
          if (cnt_q == LAST_C) begin
            shift_q[bit_idx_q] <= rx_s;
            cnt_q              <= '0;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            if (rx_s) begin
              // Leaving at the stop-bit mid-point allows zero-gap frames.
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              frame_error_q <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= S_BREAK;
            end
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        S_BREAK: begin
          // Hold here while the line stays low so it is not re-read as frames.
          if (rx_s) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= S_BREAK;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign RX_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a bench-side serial transmitter drives RX_in, and a
// queue of expected bytes (every frame sent with a high stop bit) is compared
// against the bytes captured on data_valid strobes.

module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst_n;
  logic       RX_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       RX_busy;

  int n_cmp = 0;
  int n_err = 0;

  int cycle = 0;
  int dv_count = 0;
  int fe_count = 0;
  int both_count = 0;
  int dv_cycle = 0;
  logic [7:0] got_mem [0:255];

  int rd_ptr = 0;
  int start_cycle = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q [$];

  uart_rx #(.clock_per_bit(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX_in       (RX_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .RX_busy     (RX_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Capture strobes away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        got_mem[dv_count[7:0]] <= data_out;
        dv_count <= dv_count + 1;
        dv_cycle <= cycle;
      end
      if (frame_error) fe_count <= fe_count + 1;
      if (data_valid && frame_error) both_count <= both_count + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    RX_in = v;
    step(CPB);
  endtask

  // Bench-side transmitter; records the byte as expected when the stop bit is good.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int gap);
    start_cycle = cycle;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    RX_in = 1'b1;
    if (gap > 0) step(gap);
    if (stop_v) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    RX_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    n_cmp++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    n_cmp++; if (RX_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", RX_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_loopback;
    int fe0;
    fe0 = fe_count;
    send_byte(8'hAA, 1'b1, 3);
    send_byte(8'h55, 1'b1, 5);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_ptr >= dv_count) begin n_err++; $display("FAIL loopback_missing want %h", e); end
      else if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL loopback_byte got %h want %h", got_mem[rd_ptr[7:0]], e); end
      rd_ptr++;
    end
    n_cmp++; if (dv_count != rd_ptr) begin n_err++; $display("FAIL loopback_pulses got %0d want %0d", dv_count, rd_ptr); end
    n_cmp++; if (fe_count != fe0) begin n_err++; $display("FAIL loopback_frame_error got %0d want 0", fe_count - fe0); end
  endtask

  task automatic test_back_to_back;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h81, 1'b1, 5);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_ptr >= dv_count) begin n_err++; $display("FAIL b2b_missing want %h", e); end
      else if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL b2b_byte got %h want %h", got_mem[rd_ptr[7:0]], e); end
      rd_ptr++;
    end
    n_cmp++; if (dv_count != rd_ptr) begin n_err++; $display("FAIL b2b_pulses got %0d want %0d", dv_count, rd_ptr); end
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    logic seen;
    dv0 = dv_count; fe0 = fe_count; seen = 1'b0;
    RX_in = 1'b0;
    step(3);
    RX_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RX_busy) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL glitch_busy got %b want 1", seen); end
    n_cmp++; if (dv_count != dv0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", dv_count - dv0); end
    n_cmp++; if (fe_count != fe0) begin n_err++; $display("FAIL glitch_frame_error got %0d want 0", fe_count - fe0); end
    n_cmp++; if (data_out !== last_good) begin n_err++; $display("FAIL glitch_data_out got %h want %h", data_out, last_good); end
  endtask

  task automatic test_frame_error;
    int dv0, fe0, low_busy, waited;
    dv0 = dv_count; fe0 = fe_count; low_busy = 0; waited = 0;
    send_byte(8'h3C, 1'b0, 0);
    RX_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!RX_busy) low_busy++;
    end
    @(posedge clk); #1;
    n_cmp++; if (low_busy != 0) begin n_err++; $display("FAIL ferr_busy_held got %0d low cycles want 0", low_busy); end
    RX_in = 1'b1;
    while (RX_busy === 1'b1 && waited < 12) begin step(1); waited++; end
    n_cmp++; if (RX_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release got %b want 0", RX_busy); end
    step(30);
    n_cmp++; if (fe_count - fe0 != 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", fe_count - fe0); end
    n_cmp++; if (dv_count != dv0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", dv_count - dv0); end
    n_cmp++; if (data_out !== last_good) begin n_err++; $display("FAIL ferr_data_out got %h want %h", data_out, last_good); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int dv0, fe0;
    b = 8'hC3;
    dv0 = dv_count; fe0 = fe_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    RX_in = b[4];
    step(5);
    rst_n = 1'b0;
    RX_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL midrst_data_out got %h want 00", data_out); end
    n_cmp++; if (RX_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", RX_busy); end
    n_cmp++; if (data_valid !== 1'b0 || frame_error !== 1'b0) begin n_err++; $display("FAIL midrst_strobes got %b%b want 00", data_valid, frame_error); end
    step(3);
    rst_n = 1'b1;
    last_good = 8'h00;
    step(CPB * 10);
    n_cmp++; if (dv_count != dv0 || fe_count != fe0) begin n_err++; $display("FAIL midrst_aborted_pulses got %0d/%0d want 0/0", dv_count - dv0, fe_count - fe0); end
    send_byte(8'h5A, 1'b1, 5);
    void'(exp_q.pop_front());
    n_cmp++; if (dv_count - dv0 != 1) begin n_err++; $display("FAIL midrst_pulses got %0d want 1", dv_count - dv0); end
    n_cmp++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL midrst_byte got %h want 5a", data_out); end
    rd_ptr = dv_count;
  endtask

  task automatic test_latency;
    int dv0, lat;
    dv0 = dv_count;
    send_byte(8'h01, 1'b1, 5);
    void'(exp_q.pop_front());
    lat = dv_cycle - start_cycle;
    n_cmp++; if (dv_count - dv0 != 1) begin n_err++; $display("FAIL latency_pulses got %0d want 1", dv_count - dv0); end
    n_cmp++; if (lat < 97 || lat > 99) begin n_err++; $display("FAIL latency_cycles got %0d want 98+-1", lat); end
    n_cmp++; if (data_out !== 8'h01) begin n_err++; $display("FAIL latency_byte got %h want 01", data_out); end
    rd_ptr = dv_count;
  endtask

  task automatic test_random;
    int fe0;
    fe0 = fe_count;
    for (int k = 0; k < 20; k++) begin
      send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 6)));
    end
    step(5);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_ptr >= dv_count) begin n_err++; $display("FAIL random_missing want %h", e); end
      else if (got_mem[rd_ptr[7:0]] !== e) begin n_err++; $display("FAIL random_byte got %h want %h", got_mem[rd_ptr[7:0]], e); end
      rd_ptr++;
    end
    n_cmp++; if (dv_count != rd_ptr) begin n_err++; $display("FAIL random_pulses got %0d want %0d", dv_count, rd_ptr); end
    n_cmp++; if (fe_count != fe0) begin n_err++; $display("FAIL random_frame_error got %0d want 0", fe_count - fe0); end
    n_cmp++; if (both_count != 0) begin n_err++; $display("FAIL strobes_overlap got %0d want 0", both_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    RX_in = 1'b1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
